d_cache: RTL
============

Name: d_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Processor side: responder to the MEM-stage D-cache interface (ren/wen, 30-bit word address, 32-bit wdata/rdata), with a stall back to the pipeline.
- Memory side: initiator of 128-bit (4-word) block transfers to the slow data memory.
- Sits between the MEM stage and the data memory model.

Parameters:
- IDX_W, 3, index width; the cache holds 2^IDX_W blocks of 4 words each. Tag width = 28-IDX_W (25 at default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- proc_reset  input  1  synchronous active-high reset.
- proc_read  input  1  processor read request, level, held while proc_stall=1.
- proc_write  input  1  processor write request, level, held while proc_stall=1.
- proc_addr  input  30  word address: [29:2+IDX_W] tag, [1+IDX_W:2] index, [1:0] word offset.
- proc_wdata  input  32  write word, stored unmodified (no byte swap inside the cache).
- proc_rdata  output  32  read word.
- proc_stall  output  1  high while the request cannot complete this cycle.
- mem_read  output  1  block read request, held until mem_ready.
- mem_write  output  1  block write request, held until mem_ready.
- mem_addr  output  28  block address.
- mem_wdata  output  128  write-back block; word k = bits [32k+31:32k].
- mem_rdata  input  128  fill block; same word ordering.
- mem_ready  input  1  one-cycle completion pulse from memory.

Behaviour:
- Arrays: per block one valid bit, one dirty bit, a tag, and 4x32 data.
- Reset:
  - proc_reset sampled high at a posedge: state=IDLE, all valid/dirty/tag/data cleared to 0.
  - Outputs in IDLE with no request: proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- hit = valid[idx] && tag[idx]==proc_addr tag field. req = proc_read|proc_write.
- proc_rdata = data[idx][offset], driven combinationally at all times. It is only meaningful when proc_read=1 and proc_stall=0.
- IDLE (compare):
  - !req: proc_stall=0, stay in IDLE.
  - req && hit:
    - proc_stall=0 in the same cycle (zero-wait hit).
    - A write updates data[idx][offset] and sets dirty[idx]=1 at the edge.
    - Stay in IDLE.
  - req && !hit && !(valid && dirty): proc_stall=1, next state ALLOCATE.
  - req && !hit && valid && dirty: proc_stall=1, next state WRITEBACK.
- WRITEBACK:
  - proc_stall=1, mem_write=1, mem_addr={tag[idx], idx}, mem_wdata=data[idx].
  - On mem_ready: clear dirty[idx], go to ALLOCATE.
- ALLOCATE:
  - proc_stall=1, mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready: data[idx]=mem_rdata, tag updated, valid=1, dirty=0, go to IDLE.
- Completion after a miss:
  - The cycle after the fill, IDLE sees a hit and completes with stall=0.
  - A write miss merges proc_wdata on that hit cycle.
- Miss timing:
  - Clean miss with memory latency L (mem_ready in the L-th ALLOCATE cycle): proc_stall high for L+1 cycles.
  - Dirty miss: add the WRITEBACK duration.
- mem_read and mem_write are never high together. Both drop in the cycle after mem_ready because the state has changed.
- mem_ready while in IDLE is ignored.
- proc_read && proc_write together is illegal. Write takes priority and proc_rdata is unspecified.
- Reset mid-transfer (WRITEBACK/ALLOCATE):
  - Next cycle is IDLE with arrays cleared.
  - mem_read/mem_write deassert; a late mem_ready is ignored.
- Request inputs change only while proc_stall=0. Behaviour under violation is undefined.

Test Plan:
- Reset, then proc_read addr 30'h10 (idx 4, tag 0):
  - Response: stall=1, ALLOCATE with mem_read=1, mem_addr=28'h4.
  - Memory returns mem_rdata={32'h33,32'h22,32'h11,32'h00} after 3 cycles; stall held for 4 cycles.
  - Next cycle: proc_rdata=32'h00, stall=0.
- Read hit 30'h12 -> stall=0 in the same cycle, proc_rdata=32'h22, mem_read=0.
- proc_write 30'h11 data 32'hDEADBEEF (hit) -> stall=0, dirty[4]=1. Then read 30'h11 -> 32'hDEADBEEF.
- Read 30'h30 (idx 4, tag 1):
  - WRITEBACK: mem_write=1, mem_addr=28'h4, mem_wdata={32'h33,32'h22,32'hDEADBEEF,32'h00}.
  - After mem_ready: ALLOCATE with mem_addr=28'hC, mem_write=0.
  - After the fill: hit with the returned word.
- Idle with a spurious mem_ready pulse -> stall=0, mem_read=mem_write=0, no state change. Clean conflict miss 30'h50 -> no mem_write, ALLOCATE directly.
- proc_reset asserted during ALLOCATE:
  - Next cycle: mem_read=0, state IDLE.
  - A later mem_ready is ignored.
  - Re-read of 30'h10 misses again, because valid was cleared.

Source files
------------

// File: rtl/d_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a slow block-transfer data memory (4 words per block).
module d_cache #(
  parameter int IDX_W = 3
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int TAG_W = 28 - IDX_W;
  localparam int NBLK  = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NBLK-1:0]     valid_q;
  logic [NBLK-1:0]     dirty_q;
  logic [TAG_W-1:0]    tag_q  [NBLK];
  logic [3:0][31:0]    data_q [NBLK];

  logic [IDX_W-1:0]    idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic [1:0]          off_s;
  logic                hit_s;
  logic                req_s;
  logic                hit_wr_s;
  logic                wb_done_s;
  logic                fill_s;

  assign idx_s      = proc_addr[1+IDX_W:2];
  assign tag_s      = proc_addr[29:2+IDX_W];
  assign off_s      = proc_addr[1:0];
  assign hit_s      = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign req_s      = proc_read | proc_write;
  assign proc_rdata = data_q[idx_s][off_s];

  // Next-state, handshake outputs and array update strobes.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    hit_wr_s   = 1'b0;
    wb_done_s  = 1'b0;
    fill_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            hit_wr_s = proc_write;
          end else begin
            proc_stall = 1'b1;
            if (valid_q[idx_s] && dirty_q[idx_s]) begin
              state_d = WRITEBACK;
            end else begin
              state_d = ALLOCATE;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      // Victim address is rebuilt from the stored tag, not the request tag.
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx_s], idx_s};
        mem_wdata  = data_q[idx_s];
        if (mem_ready) begin
          wb_done_s = 1'b1;
          state_d   = ALLOCATE;
        end else begin
          state_d = WRITEBACK;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) begin
          fill_s  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ALLOCATE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and tag/data/valid/dirty arrays.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NBLK; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (hit_wr_s) begin
        data_q[idx_s][off_s] <= proc_wdata;
        dirty_q[idx_s]       <= 1'b1;
      end
      if (wb_done_s) begin
        dirty_q[idx_s] <= 1'b0;
      end
      if (fill_s) begin
        data_q[idx_s]  <= mem_rdata;
        tag_q[idx_s]   <= tag_s;
        valid_q[idx_s] <= 1'b1;
        dirty_q[idx_s] <= 1'b0;
      end
    end
  end

endmodule
